// File: rtl/game_pkg.sv
// game_pkg: screen state codes, bump codes, per-type score values and the
// platform type-priority rank. Shared by the play controller, the doodle
// mover and the VGA renderer so every block decodes the same encodings.
package game_pkg;

  // Screen FSM codes; 5..7 are never produced and recover to WAIT.
  typedef enum logic [2:0] {
    ST_WAIT = 3'd0,
    ST_INFO = 3'd1,
    ST_GAME = 3'd2,
    ST_WIN  = 3'd3,
    ST_LOSE = 3'd4
  } state_e;

  // Bump codes handed to the doodle mover; also the platform type encoding.
  typedef enum logic [2:0] {
    BUMP_NOTHING = 3'd0,
    BUMP_GREEN   = 3'd1,
    BUMP_BLUE    = 3'd2,
    BUMP_ORANGE  = 3'd3,
    BUMP_YELLOW  = 3'd4
  } bump_e;

  // Cycles after a bump during which further bumps are masked
  // (only used when HIT_LOCKOUT_EN is defined).
  localparam logic [3:0]  LOCKOUT   = 4'd6;
  localparam logic [13:0] SCORE_MAX = 14'h3FFF;

  // Higher rank wins arbitration: YELLOW > BLUE > ORANGE > GREEN.
  // Unknown codes (0, 5..7) rank 0 so they never produce a bump.
  function automatic logic [2:0] bump_rank(input logic [2:0] t);
    case (t)
      3'd4:    bump_rank = 3'd4;
      3'd2:    bump_rank = 3'd3;
      3'd3:    bump_rank = 3'd2;
      3'd1:    bump_rank = 3'd1;
      default: bump_rank = 3'd0;
    endcase
  endfunction

  // Points awarded for an issued bump.
  function automatic logic [1:0] bump_points(input logic [2:0] b);
    case (b)
      3'd1:    bump_points = 2'd1;
      3'd2:    bump_points = 2'd3;
      3'd3:    bump_points = 2'd2;
      3'd4:    bump_points = 2'd1;
      default: bump_points = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/bump_arbiter.sv
// bump_arbiter: purely combinational priority select over the platform
// collision requesters. The highest-ranked type wins; among equal types the
// lowest platform index wins. The sequencer registers the result.
module bump_arbiter
  import game_pkg::*;
#(
  parameter int N_PLAT = 8
) (
  input  logic [N_PLAT-1:0]   plat_hit_i,
  input  logic [3*N_PLAT-1:0] plat_type_i,
  output logic                valid_o,
  output logic [2:0]          type_o
);

  logic [N_PLAT-1:0][2:0] rank_w;
  logic [2:0]             best_rank;

  // Per-platform rank; a platform not being touched ranks 0.
  for (genvar g = 0; g < N_PLAT; g++) begin : g_rank
    assign rank_w[g] = plat_hit_i[g] ? bump_rank(plat_type_i[3*g +: 3]) : 3'd0;
  end

  // Scan upward with a strict compare so the lowest index keeps a tie.
  always_comb begin
    best_rank = 3'd0;
    type_o    = BUMP_NOTHING;
    for (int i = 0; i < N_PLAT; i++) begin
      if (rank_w[i] > best_rank) begin
        best_rank = rank_w[i];
        type_o    = plat_type_i[3*i +: 3];
      end
    end
  end

  assign valid_o = (best_rank != 3'd0);

endmodule

// File: rtl/game_sequencer.sv
// game_sequencer: play controller for the doodle datapath. Runs the screen
// FSM, turns platform collisions into a one-cycle registered bump code for
// the mover, keeps a saturating score and detects win/lose.
// Optional feature: define HIT_LOCKOUT_EN to mask new bumps for LOCKOUT
// cycles after each issued bump.
module game_sequencer
  import game_pkg::*;
#(
  parameter int          N_PLAT    = 8,
  parameter logic [9:0]  BOTTOM_Y  = 10'd440,
  parameter logic [13:0] WIN_SCORE = 14'd500
) (
  input  logic                clk_22,
  input  logic                rst,
  input  logic                key_start,
  input  logic                key_info,
  input  logic [N_PLAT-1:0]   plat_hit,
  input  logic [3*N_PLAT-1:0] plat_type,
  input  logic [9:0]          doodle_y,
  input  logic                fly,
  input  logic                invincible,
  input  logic                monster_hit,
  output logic [2:0]          state,
  output logic [2:0]          bump,
  output logic [13:0]         score
);

  state_e      state_q, state_d;
  logic [2:0]  bump_q, bump_d;
  logic [13:0] score_q, score_d;
  logic [14:0] score_sum;
  logic        lose;
  logic        locked;
  logic        arb_en;
  logic        arb_valid;
  logic [2:0]  arb_type;

  bump_arbiter #(.N_PLAT(N_PLAT)) u_arb (
    .plat_hit_i  (plat_hit),
    .plat_type_i (plat_type),
    .valid_o     (arb_valid),
    .type_o      (arb_type)
  );

  // A falling doodle below the floor, or an unshielded monster touch, ends the game.
  assign lose = (!fly && (doodle_y >= BOTTOM_Y)) || (monster_hit && !invincible);

  // Screen FSM next state; lose takes precedence over win.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_WAIT: begin
        if (key_start)     state_d = ST_GAME;
        else if (key_info) state_d = ST_INFO;
      end
      ST_INFO: begin
        if (key_start || key_info) state_d = ST_WAIT;
      end
      ST_GAME: begin
        if (lose)                      state_d = ST_LOSE;
        else if (score_q >= WIN_SCORE) state_d = ST_WIN;
      end
      ST_WIN, ST_LOSE: begin
        if (key_start) state_d = ST_WAIT;
      end
      default: state_d = ST_WAIT;
    endcase
  end

  // Bumps only while staying in GAME, only when falling, only when not masked.
  always_comb begin
    arb_en = (state_q == ST_GAME) && (state_d == ST_GAME) && !fly && !locked;
    bump_d = (arb_en && arb_valid) ? arb_type : BUMP_NOTHING;
  end

  // Score follows the bump being registered on the same edge, so it updates
  // together with the bump output; starting a game clears it.
  always_comb begin
    score_sum = {1'b0, score_q} + {13'd0, bump_points(bump_d)};
    if ((state_q == ST_WAIT) && key_start)
      score_d = 14'd0;
    else if (score_sum > {1'b0, SCORE_MAX})
      score_d = SCORE_MAX;
    else
      score_d = score_sum[13:0];
  end

`ifdef HIT_LOCKOUT_EN
  logic [3:0] lock_q, lock_d;

  assign locked = (lock_q != 4'd0);

  // Lockout counter: reload on each issued bump, drain to 0, idle outside GAME.
  always_comb begin
    lock_d = lock_q;
    if (state_q != ST_GAME)         lock_d = 4'd0;
    else if (bump_d != BUMP_NOTHING) lock_d = LOCKOUT;
    else if (lock_q != 4'd0)        lock_d = lock_q - 4'd1;
  end

  // Lockout counter register.
  always_ff @(posedge clk_22) begin
    if (rst) lock_q <= 4'd0;
    else     lock_q <= lock_d;
  end
`else
  assign locked = 1'b0;
`endif

  // State, bump and score registers with synchronous reset.
  always_ff @(posedge clk_22) begin
    if (rst) begin
      state_q <= ST_WAIT;
      bump_q  <= BUMP_NOTHING;
      score_q <= 14'd0;
    end else begin
      state_q <= state_d;
      bump_q  <= bump_d;
      score_q <= score_d;
    end
  end

  assign state = state_q;
  assign bump  = bump_q;
  assign score = score_q;

endmodule
